load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/lsu_lane_align.sv | 37 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit and the data-bus slaves.
package lsu_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
  } req_attr_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_H:  return {lo[1], 1'b0};
      SIZE_W:  return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-bus control signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] data_address;
  logic        data_cs;
  logic        data_rw;
  logic [1:0]  data_mode;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output data_address, data_cs, data_rw, data_mode
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  data_address, data_cs, data_rw, data_mode
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: store replication and load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bus,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wdata = i_wdata;
    case (i_size)
      SIZE_B:  o_wdata = {4{i_wdata[7:0]}};
      SIZE_H:  o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  always_comb begin
    w_byte  = i_bus[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_bus[31:16] : i_bus[15:0];
    o_rdata = i_bus;
    case (i_size)
      SIZE_B:  o_rdata = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      SIZE_H:  o_rdata = i_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default: o_rdata = i_bus;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side bus master: one aligned load/store at a time, WAIT_CYCLES bus cycles per access.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word requests instead of aligning down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.master   bus,
  inout  wire  [31:0]         data_bus
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  req_attr_t   r_attr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_cs;
  logic        r_rw;
  logic [1:0]  r_mode;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_fault_req;
  logic [1:0]  w_lo_eff;
  logic        w_idle;
  logic [1:0]  w_al_size;
  logic [1:0]  w_al_lo;
  logic        w_al_signed;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_bus_oe;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_fault_req = (bus.req_size == SIZE_RSV) || is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign w_lo_eff    = bus.req_addr[1:0];
`else
  assign w_fault_req = (bus.req_size == SIZE_RSV);
  assign w_lo_eff    = align_lo(bus.req_size, bus.req_addr[1:0]);
`endif

  assign w_accept = bus.req_valid && r_ready;
  assign w_idle   = (r_state == ST_IDLE);

  // One aligner serves both directions: request fields while idle, latched ones during the access.
  assign w_al_size   = w_idle ? bus.req_size   : r_attr.size;
  assign w_al_lo     = w_idle ? w_lo_eff       : r_addr[1:0];
  assign w_al_signed = w_idle ? bus.req_signed : r_attr.sgn;

  lsu_lane_align u_align (
    .i_size    (w_al_size),
    .i_addr_lo (w_al_lo),
    .i_signed  (w_al_signed),
    .i_wdata   (bus.req_wdata),
    .i_bus     (data_bus),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  assign w_bus_oe = (r_state == ST_ACCESS) && r_attr.we;
  assign data_bus = w_bus_oe ? r_wdata : 'z;

  assign bus.req_ready    = r_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_fault   = r_resp_fault;
  assign bus.resp_rdata   = r_resp_rdata;
  assign bus.data_address = r_addr;
  assign bus.data_cs      = r_cs;
  assign bus.data_rw      = r_rw;
  assign bus.data_mode    = r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_attr       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_cs         <= 1'b0;
      r_rw         <= RW_READ;
      r_mode       <= SIZE_B;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_attr  <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed};
            r_wdata <= w_lane_wdata;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            if (w_fault_req) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_ACCESS;
              r_cs    <= 1'b1;
              r_addr  <= {bus.req_addr[31:2], w_lo_eff};
              r_rw    <= bus.req_we ? RW_WRITE : RW_READ;
              r_mode  <= bus.req_size;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == LAST_CNT) begin
            r_cs         <= 1'b0;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= r_attr.we ? '0 : w_lane_rdata;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          // A fault enters RESP with no strobe yet, so its response lands one cycle after accept.
          if (r_resp_valid) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
            r_resp_rdata <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word-addressed bus slave.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned W = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int unsigned acc;
    int unsigned lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [1:0]  mode;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [31:0] data_bus;
  logic [31:0] mem [0:63];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned cs_run = 0;
  resp_t       resp_q[$];
  bus_t        bus_q[$];
  resp_t       r_pop;
  bus_t        b_pop;

  load_store_unit_if ifc ();

  load_store_unit #(.WAIT_CYCLES(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_bus = (ifc.data_cs && (ifc.data_rw == RW_READ)) ? mem[ifc.data_address[7:2]] : 'z;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFEF00D;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11223344;
    forever begin
      @(negedge clk);
      if (ifc.data_cs && (ifc.data_rw == RW_WRITE)) begin
        case (ifc.data_mode)
          SIZE_B: mem[ifc.data_address[7:2]][{ifc.data_address[1:0], 3'b000} +: 8] =
                    data_bus[{ifc.data_address[1:0], 3'b000} +: 8];
          SIZE_H: mem[ifc.data_address[7:2]][{ifc.data_address[1], 4'b0000} +: 16] =
                    data_bus[{ifc.data_address[1], 4'b0000} +: 16];
          default: mem[ifc.data_address[7:2]] = data_bus;
        endcase
      end
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_run = 0;
    end else begin
      if (ifc.resp_valid) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          r_pop = resp_q.pop_front();
          check("resp_rdata", ifc.resp_rdata, r_pop.rdata);
          check("resp_fault", 32'(ifc.resp_fault), 32'(r_pop.fault));
          check("resp_latency", 32'(cyc - r_pop.acc), 32'(r_pop.lat));
        end
      end
      if (ifc.data_cs) begin
        if (cs_run == 0) begin
          if (bus_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_bus: got data_cs=1 addr=%h expected no access", ifc.data_address);
          end else begin
            b_pop = bus_q.pop_front();
            check("data_address", ifc.data_address, b_pop.addr);
            check("data_rw", 32'(ifc.data_rw), 32'(b_pop.rw));
            check("data_mode", 32'(ifc.data_mode), 32'(b_pop.mode));
            if (b_pop.rw == RW_WRITE) check("data_bus", data_bus, b_pop.wdata);
          end
        end
        cs_run++;
      end else if (cs_run != 0) begin
        check("cs_cycles", 32'(cs_run), 32'(W));
        cs_run = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault,
                       input logic [31:0] exp_baddr, input logic [31:0] exp_bdata,
                       output int unsigned acc, output int unsigned waited);
    waited = 0;
    @(negedge clk);
    while (!ifc.req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ifc.req_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
    end
    ifc.req_valid  = 1'b1;
    ifc.req_we     = we;
    ifc.req_size   = size;
    ifc.req_signed = sgn;
    ifc.req_addr   = addr;
    ifc.req_wdata  = wdata;
    acc = cyc;
    resp_q.push_back('{rdata: exp_rdata, fault: exp_fault, acc: acc, lat: exp_fault ? 2 : W + 1});
    if (!exp_fault) bus_q.push_back('{addr: exp_baddr, rw: we, mode: size, wdata: exp_bdata});
    @(posedge clk);
    #1 ifc.req_valid = 1'b0;
  endtask

  int unsigned acc_a, acc_b, wt;
  logic        trap;

  initial begin
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    ifc.req_valid  = 1'b0;
    ifc.req_we     = 1'b0;
    ifc.req_size   = SIZE_B;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("rst_resp_rdata", ifc.resp_rdata, 32'd0);
    check("rst_resp_fault", 32'(ifc.resp_fault), 32'd0);
    check("rst_data_cs", 32'(ifc.data_cs), 32'd0);
    check("rst_data_rw", 32'(ifc.data_rw), 32'd0);
    check("rst_data_mode", 32'(ifc.data_mode), 32'd0);
    check("rst_data_address", ifc.data_address, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, SIZE_W, 1'b0, 32'h80000010, 32'h0, 32'hDEADBEEF, 1'b0, 32'h80000010, 32'h0, acc_a, wt);
    issue(1'b1, SIZE_W, 1'b0, 32'h80000010, 32'h80FF7F01, 32'h0, 1'b0, 32'h80000010, 32'h80FF7F01, acc_a, wt);
    issue(1'b0, SIZE_B, 1'b1, 32'h80000013, 32'h0, 32'hFFFFFF80, 1'b0, 32'h80000013, 32'h0, acc_a, wt);
    issue(1'b0, SIZE_B, 1'b0, 32'h80000013, 32'h0, 32'h00000080, 1'b0, 32'h80000013, 32'h0, acc_a, wt);
    issue(1'b0, SIZE_B, 1'b1, 32'h80000012, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h80000012, 32'h0, acc_a, wt);
    issue(1'b0, SIZE_B, 1'b1, 32'h80000011, 32'h0, 32'h0000007F, 1'b0, 32'h80000011, 32'h0, acc_a, wt);
    issue(1'b0, SIZE_H, 1'b1, 32'h80000012, 32'h0, 32'hFFFF80FF, 1'b0, 32'h80000012, 32'h0, acc_a, wt);
    issue(1'b0, SIZE_H, 1'b0, 32'h80000010, 32'h0, 32'h00007F01, 1'b0, 32'h80000010, 32'h0, acc_a, wt);
    issue(1'b1, SIZE_H, 1'b0, 32'h80000022, 32'h0000A5C3, 32'h0, 1'b0, 32'h80000022, 32'hA5C3A5C3, acc_a, wt);
    issue(1'b0, SIZE_W, 1'b0, 32'h80000020, 32'h0, 32'hA5C33344, 1'b0, 32'h80000020, 32'h0, acc_a, wt);
    issue(1'b1, SIZE_B, 1'b0, 32'h80000021, 32'h1234565A, 32'h0, 1'b0, 32'h80000021, 32'h5A5A5A5A, acc_a, wt);
    issue(1'b0, SIZE_W, 1'b0, 32'h80000020, 32'h0, 32'hA5C35A44, 1'b0, 32'h80000020, 32'h0, acc_a, wt);

    if (trap) begin
      issue(1'b0, SIZE_W, 1'b0, 32'h80000002, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, acc_a, wt);
      issue(1'b0, SIZE_H, 1'b0, 32'h80000001, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, acc_a, wt);
    end else begin
      issue(1'b0, SIZE_W, 1'b0, 32'h80000002, 32'h0, 32'hCAFEF00D, 1'b0, 32'h80000000, 32'h0, acc_a, wt);
      issue(1'b0, SIZE_H, 1'b0, 32'h80000001, 32'h0, 32'h0000F00D, 1'b0, 32'h80000000, 32'h0, acc_a, wt);
    end
    issue(1'b0, SIZE_RSV, 1'b0, 32'h80000004, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, acc_a, wt);
    issue(1'b1, SIZE_RSV, 1'b0, 32'h80000004, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 32'h0, acc_a, wt);

    issue(1'b0, SIZE_W, 1'b0, 32'h80000010, 32'h0, 32'h80FF7F01, 1'b0, 32'h80000010, 32'h0, acc_a, wt);
    issue(1'b0, SIZE_W, 1'b0, 32'h80000010, 32'h0, 32'h80FF7F01, 1'b0, 32'h80000010, 32'h0, acc_b, wt);
    check("b2b_accept_spacing", 32'(acc_b - acc_a), 32'(W + 2));
    check("b2b_ready_low_cycles", 32'(wt), 32'(W + 1));

    issue(1'b0, SIZE_W, 1'b0, 32'h80000020, 32'h0, 32'h0, 1'b0, 32'h80000020, 32'h0, acc_a, wt);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data_cs", 32'(ifc.data_cs), 32'd0);
    check("midrst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("midrst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("midrst_data_address", ifc.data_address, 32'd0);
    resp_q.delete();
    bus_q.delete();
    #9 rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    check("postrst_req_ready", 32'(ifc.req_ready), 32'd1);

    issue(1'b0, SIZE_W, 1'b0, 32'h80000020, 32'h0, 32'hA5C35A44, 1'b0, 32'h80000020, 32'h0, acc_a, wt);

    for (int i = 0; i < 50 && (resp_q.size() != 0 || bus_q.size() != 0); i++) @(negedge clk);
    if (resp_q.size() != 0 || bus_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d responses and %0d accesses pending expected 0",
               resp_q.size(), bus_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
